// File: rtl/sub_pkg.sv
// Shared FSM state encoding for the bit-serial subtractor controller.
// No latency or flow control applies here.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fullsub_cell.sv
// One-bit full subtractor (a - b - bin), purely combinational.
// Zero latency; no flow control.
module fullsub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bitserial_sub_ctrl.sv
// Serial a-b, one bit per cycle LSB first; done pulses WIDTH edges after start is accepted.
// start is ignored while busy; abort cancels a running op without touching diff/bout.
module bitserial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic [IW-1:0]    idx;
    logic             bw;
    logic             cell_d;
    logic             cell_bout;
    logic             load;
    logic             step;
    logic             last_bit;

    fullsub_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last_bit = (idx == LAST);
    // New result bit enters at the MSB so after WIDTH steps bit 0 sits at the LSB.
    assign res_nxt  = (res_sr >> 1) | {cell_d, {(WIDTH-1){1'b0}}};

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (last_bit) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            idx    <= '0;
            bw     <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            idx    <= '0;
            bw     <= 1'b0;
        end else if (step) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt;
            bw     <= cell_bout;
            idx    <= last_bit ? '0 : idx + IW'(1);
            if (last_bit) begin
                diff <= res_nxt;
                bout <= cell_bout;
            end
        end
    end

endmodule

// File: doc/bitserial_sub_ctrl.md
BITSERIAL_SUB_CTRL -- requirements
Module: bitserial_sub_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a subtraction; sampled on rising edge.
REQ-005 SHALL have port: abort  input  1  synchronous cancel of an operation in progress.
REQ-006 SHALL have port: a  input  WIDTH  minuend; sampled only on the edge that accepts start.
REQ-007 SHALL have port: b  input  WIDTH  subtrahend; sampled only on the edge that accepts start.
REQ-008 SHALL have port: busy  output  1  high while the serial operation runs.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-011 SHALL have port: bout  output  1  final borrow; 1 when a < b (unsigned).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE, with all outputs registered.
REQ-013 SHALL accept start in IDLE or DONE: latch a and b, clear internal borrow, set bit index 0, go to RUN.
REQ-014 SHALL ignore start while in RUN, with no effect on latched operands or timing.
REQ-015 SHALL process one bit per RUN cycle, LSB first, using one full-subtractor cell: d = ai^bi^bw; bw_next = (~ai&bi) | (~(ai^bi)&bw).
REQ-016 SHALL stay in RUN for exactly WIDTH rising edges after the accepting edge, then enter DONE.
REQ-017 SHALL hold busy high in RUN and low in IDLE and DONE.
REQ-018 SHALL, on entering DONE, load diff with the assembled result and bout with the final borrow, and assert done.
REQ-019 SHALL assert done for exactly one cycle; DONE returns to IDLE on the next edge unless start is high, in which case it goes directly to RUN.
REQ-020 SHALL keep diff and bout stable from DONE entry until the next DONE entry; they SHALL NOT change during RUN.
REQ-021 SHALL, on abort in RUN, go to IDLE on that edge without asserting done and without changing diff or bout.
REQ-022 SHALL give abort priority over start when both are high on the same edge; abort outside RUN has no effect.
REQ-023 SHALL use a bit-index counter of width clog2(WIDTH), compared against WIDTH-1 for the last bit; no wrap-around beyond WIDTH-1.

Reset
REQ-024 SHALL, on rst high, immediately (without waiting for a clock edge) force state=IDLE, busy=0, done=0, diff=0, bout=0, internal borrow=0 and index=0.
REQ-025 SHALL abandon any operation in progress when rst is asserted, so no done pulse is generated for it after release.
REQ-026 SHALL allow start to be accepted on the first rising edge after rst deasserts.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) in shared package sub_pkg.
REQ-028 SHALL instantiate exactly one sub-module, fullsub_cell: a purely combinational 1-bit full subtractor with inputs a, b, bin and outputs d, bout.
REQ-029 SHALL hold the operands in shift registers, and SHALL assemble the result LSB-first into an internal shift register.

Verification (WIDTH=8)
REQ-030 SHALL verify a=0x05, b=0x03, start pulse -> busy for 8 cycles; done appears after the 8th edge following the accepting edge; diff=0x02, bout=0.
REQ-031 SHALL verify a=0x03, b=0x05 -> diff=0xFE, bout=1; a=0x00, b=0xFF -> diff=0x01, bout=1; a=0xFF, b=0xFF -> diff=0x00, bout=0.
REQ-032 SHALL verify that after a=0x10, b=0x01 is accepted, applying start with a=0x00, b=0x01 at RUN cycle 3 -> ignored; result is diff=0x0F, bout=0, with a single done.
REQ-033 SHALL verify that start held high through DONE -> back-to-back operation with no IDLE cycle; the second done arrives 9 edges after the first.
REQ-034 SHALL verify that abort at RUN cycle 4 -> IDLE next edge; no done; diff and bout keep their previous values.
REQ-035 SHALL verify that rst asserted between clock edges mid-RUN -> all outputs 0 immediately; after release, no spurious done, and a new start completes correctly.
